// File: rtl/bullet_pool_controller.sv
// Round-robin pool of upward-moving bullet slots launched from a fire button.
// Optional launch cooldown is enabled by defining BULLET_COOLDOWN_EN.
module bullet_pool_controller #(
  parameter int NUM_SLOTS      = 4,
  parameter int TICK_BIT       = 17,
  parameter int BULLET_SPEED   = 2,
  parameter int COOLDOWN_TICKS = 16,
  parameter int SPRITE_W       = 32,
  parameter int BULLET_W       = 4,
  parameter int BULLET_H       = 8
) (
  input  logic                    clk25,
  input  logic                    rst,
  input  logic                    btn_fire,
  input  logic [9:0]              sprite_x,
  input  logic [9:0]              sprite_y,
  output logic [10*NUM_SLOTS-1:0] bullet_x,
  output logic [10*NUM_SLOTS-1:0] bullet_y,
  output logic [NUM_SLOTS-1:0]    bullet_active,
  output logic                    fire_ack,
  output logic                    pool_full
);

  localparam int RR_W = $clog2(NUM_SLOTS);
  localparam logic [9:0] SPEED10  = 10'(BULLET_SPEED);
  localparam logic [9:0] XOFS10   = 10'(SPRITE_W / 2 - BULLET_W / 2);
  localparam logic [9:0] BH10     = 10'(BULLET_H);

  logic [19:0]           move_cnt;
  logic                  tick;
  logic                  btn_fire_p1;
  logic                  armed;
  logic                  fire_rise;
  logic                  fire_pending;
  logic [RR_W-1:0]       rr;
  logic [RR_W-1:0]       chosen;
  logic [RR_W-1:0]       probe;
  logic                  free_found;
  logic                  cd_block;
  logic                  launch;
  logic [9:0]            slot_x [NUM_SLOTS];
  logic [9:0]            slot_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_act;

  function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? 10'd0 : a - b;
  endfunction

  assign tick = move_cnt[TICK_BIT];

  // armed stays low after reset until the button is seen released, so a
  // button held through reset cannot produce a launch.
  assign fire_rise = btn_fire & ~btn_fire_p1 & armed;

  always_comb begin
    free_found = 1'b0;
    chosen     = '0;
    probe      = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      probe = RR_W'((int'(rr) + k) % NUM_SLOTS);
      if (!free_found && !slot_act[probe]) begin
        free_found = 1'b1;
        chosen     = probe;
      end
    end
  end

`ifdef BULLET_COOLDOWN_EN
  logic [15:0] cd_cnt;

  assign cd_block = (cd_cnt != 16'd0);

  always_ff @(posedge clk25) begin
    if (rst) begin
      cd_cnt <= 16'd0;
    end else if (launch) begin
      cd_cnt <= 16'(COOLDOWN_TICKS);
    end else if (tick && cd_cnt != 16'd0) begin
      cd_cnt <= cd_cnt - 16'd1;
    end
  end
`else
  assign cd_block = 1'b0;
`endif

  assign launch = fire_pending & free_found & ~cd_block;

  always_ff @(posedge clk25) begin
    if (rst) begin
      move_cnt     <= 20'd0;
      btn_fire_p1  <= 1'b0;
      armed        <= 1'b0;
      fire_pending <= 1'b0;
      rr           <= '0;
      fire_ack     <= 1'b0;
    end else begin
      move_cnt     <= tick ? 20'd0 : move_cnt + 20'd1;
      btn_fire_p1  <= btn_fire;
      if (!btn_fire) armed <= 1'b1;
      fire_pending <= launch ? 1'b0 : (fire_pending | fire_rise);
      if (launch) rr <= RR_W'((int'(chosen) + 1) % NUM_SLOTS);
      fire_ack     <= launch;
    end
  end

  // A freshly launched slot was inactive, so it never also takes the tick move.
  always_ff @(posedge clk25) begin
    if (rst) begin
      slot_act <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_x[i] <= 10'd0;
        slot_y[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (launch && chosen == RR_W'(i)) begin
          slot_act[i] <= 1'b1;
          slot_x[i]   <= sprite_x + XOFS10;
          slot_y[i]   <= sat_sub10(sprite_y, BH10);
        end else if (tick && slot_act[i]) begin
          if (slot_y[i] < SPEED10) begin
            slot_act[i] <= 1'b0;
            slot_x[i]   <= 10'd0;
            slot_y[i]   <= 10'd0;
          end else begin
            slot_y[i]   <= sat_sub10(slot_y[i], SPEED10);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bullet_x[10*g +: 10] = slot_x[g];
    assign bullet_y[10*g +: 10] = slot_y[g];
  end

  assign bullet_active = slot_act;
  assign pool_full     = &slot_act;

endmodule

// File: tb/tb_bullet_pool_controller.sv
// Bench for bullet_pool_controller: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_bullet_pool_controller;

  localparam int N   = 4;
  localparam int TBT = 3;
  localparam int SPD = 2;
  localparam int CD  = 3;
  localparam int SW  = 32;
  localparam int BW  = 4;
  localparam int BH  = 8;
  localparam int PER = (1 << TBT) + 1;

  logic           clk25 = 1'b0;
  logic           rst = 1'b1;
  logic           btn_fire = 1'b0;
  logic [9:0]     sprite_x = 10'd0;
  logic [9:0]     sprite_y = 10'd0;
  logic [10*N-1:0] bullet_x, bullet_y;
  logic [N-1:0]   bullet_active;
  logic           fire_ack, pool_full;

  always #20 clk25 = ~clk25;

  bullet_pool_controller #(
    .NUM_SLOTS(N), .TICK_BIT(TBT), .BULLET_SPEED(SPD), .COOLDOWN_TICKS(CD),
    .SPRITE_W(SW), .BULLET_W(BW), .BULLET_H(BH)
  ) dut (
    .clk25(clk25), .rst(rst), .btn_fire(btn_fire),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .fire_ack(fire_ack), .pool_full(pool_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: slot contents plus the game rules, cycle count since reset.
  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_pend, m_rr, m_prev, m_seen_release, m_ack, m_cyc, m_cd;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic b, input int sx, input int sy);
    int is_tick, rise, found, ch, fire;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_pend = 0; m_rr = 0; m_prev = 0; m_seen_release = 0; m_ack = 0; m_cyc = 0; m_cd = 0;
      return;
    end
    is_tick = ((m_cyc % PER) == PER - 1);
    rise    = (b && !m_prev && m_seen_release);
    found = 0; ch = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && !m_act[(m_rr + k) % N]) begin found = 1; ch = (m_rr + k) % N; end
    end
    fire = (m_pend && found && m_cd == 0);
    for (int i = 0; i < N; i++) begin
      if (fire && i == ch) begin
        m_act[i] = 1;
        m_x[i]   = (sx + SW / 2 - BW / 2) % 1024;
        m_y[i]   = (sy < BH) ? 0 : sy - BH;
      end else if (is_tick && m_act[i]) begin
        if (m_y[i] < SPD) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        else m_y[i] = m_y[i] - SPD;
      end
    end
    m_pend = fire ? 0 : (m_pend | rise);
    if (fire) m_rr = (ch + 1) % N;
    m_ack = fire;
`ifdef BULLET_COOLDOWN_EN
    if (fire) m_cd = CD;
    else if (is_tick && m_cd > 0) m_cd = m_cd - 1;
`endif
    if (!b) m_seen_release = 1;
    m_prev = b;
    m_cyc++;
  endtask

  task automatic check_model();
    logic [10*N-1:0] ex, ey;
    logic [N-1:0]    ea;
    int              all;
    all = 1;
    for (int i = 0; i < N; i++) begin
      ea[i] = (m_act[i] != 0);
      ex[10*i +: 10] = 10'(m_x[i]);
      ey[10*i +: 10] = 10'(m_y[i]);
      if (!m_act[i]) all = 0;
    end
    chk("model_active", bullet_active, ea);
    chk("model_x", bullet_x, ex);
    chk("model_y", bullet_y, ey);
    chk("model_ack", fire_ack, m_ack[0]);
    chk("model_full", pool_full, all[0]);
  endtask

  task automatic cycle(input logic r, input logic b, input int sx, input int sy);
    rst = r; btn_fire = b; sprite_x = sx[9:0]; sprite_y = sy[9:0];
    model_step(r, b, sx, sy);
    @(posedge clk25);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 50, 200);
  endtask

  task automatic press(input int sy);
    cycle(1'b0, 1'b1, 50, sy);
    cycle(1'b0, 1'b0, 50, sy);
  endtask

  typedef struct {
    logic       r;
    logic       b;
    int         sx;
    int         sy;
    logic       ack;
    logic [3:0] act;
    int         x0;
    int         y0;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic b, input int sx, input int sy,
                      input logic ack, input logic [3:0] act, input int x0, input int y0);
    vec_t v;
    v.r = r; v.b = b; v.sx = sx; v.sy = sy; v.ack = ack; v.act = act; v.x0 = x0; v.y0 = y0;
    vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] cur;
    int           waited, seen_ack, got_free;

    // Launch from (100,200), then one tick; then launch near the top edge.
    addv(1, 0, 100, 200, 0, 4'b0000, 0, 0);
    addv(0, 0, 100, 200, 0, 4'b0000, 0, 0);
    addv(0, 1, 100, 200, 0, 4'b0000, 0, 0);
    addv(0, 1, 100, 200, 1, 4'b0001, 114, 192);
    for (int i = 0; i < 5; i++) addv(0, 0, 100, 200, 0, 4'b0001, 114, 192);
    addv(0, 0, 100, 200, 0, 4'b0001, 114, 190);
    addv(1, 0, 100, 4, 0, 4'b0000, 0, 0);
    addv(0, 0, 100, 4, 0, 4'b0000, 0, 0);
    addv(0, 1, 100, 4, 0, 4'b0000, 0, 0);
    addv(0, 1, 100, 4, 1, 4'b0001, 114, 0);
    for (int i = 0; i < 5; i++) addv(0, 0, 100, 4, 0, 4'b0001, 114, 0);
    addv(0, 0, 100, 4, 0, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].b, vecs[i].sx, vecs[i].sy);
      chk($sformatf("vec%0d_ack", i), fire_ack, vecs[i].ack);
      chk($sformatf("vec%0d_act", i), bullet_active, vecs[i].act);
      chk($sformatf("vec%0d_x0", i), bullet_x[9:0], 10'(vecs[i].x0));
      chk($sformatf("vec%0d_y0", i), bullet_y[9:0], 10'(vecs[i].y0));
    end

    // Fill the pool, fifth press waits until a slot frees.
    cycle(1'b1, 1'b0, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) press(200);
    chk("fill_full", pool_full, 1'b1);
    press(200);
    idle(3);
    chk("fill_pending_no_ack", fire_ack, 1'b0);
    chk("fill_active", bullet_active, 4'b1111);
    got_free = 0;
    for (int i = 0; i < 2000 && !got_free; i++) begin
      idle(1);
      if (!pool_full) got_free = 1;
    end
    chk("fill_slot_freed", got_free, 1);
    cur = bullet_active;
    chk("fill_no_ack_on_free", fire_ack, 1'b0);
    idle(1);
    chk("fill_late_ack", fire_ack, 1'b1);
    chk("fill_late_slot", bullet_active, cur | (cur + 4'd1));

    // Wrap-around search: only slot 1 free while rr points at slot 2.
    cycle(1'b1, 1'b0, 0, 0);
    idle(1);
    press(4); press(4); press(200); press(200);
    chk("wrap_after_first_tick", bullet_active, 4'b1100);
    press(200); press(4);
    chk("wrap_all_active", bullet_active, 4'b1111);
    idle(5);
    chk("wrap_slot1_freed", bullet_active, 4'b1101);
    press(200);
    chk("wrap_ack", fire_ack, 1'b1);
    chk("wrap_active", bullet_active, 4'b1111);
    chk("wrap_slot1_y", bullet_y[19:10], 10'd192);

    // Two quick presses, with and without cooldown.
    cycle(1'b1, 1'b0, 0, 0);
    idle(1);
    press(200);
    chk("cd_first_ack", fire_ack, 1'b1);
    press(200);
`ifdef BULLET_COOLDOWN_EN
    chk("cd_second_blocked", fire_ack, 1'b0);
    waited = 0;
    for (int i = 0; i < 100 && !fire_ack; i++) begin
      idle(1);
      waited++;
    end
    chk("cd_second_delay", waited, 23);
`else
    chk("nocd_second_ack", fire_ack, 1'b1);
    chk("nocd_second_active", bullet_active, 4'b0011);
`endif

    // Reset on a launch+tick cycle with the button held.
    cycle(1'b1, 1'b0, 0, 0);
    idle(1);
    press(200);
    idle(4);
    cycle(1'b0, 1'b1, 50, 200);
    cycle(1'b1, 1'b1, 50, 200);
    chk("rst_active", bullet_active, 4'b0000);
    chk("rst_ack", fire_ack, 1'b0);
    chk("rst_x", bullet_x, '0);
    chk("rst_y", bullet_y, '0);
    chk("rst_full", pool_full, 1'b0);
    seen_ack = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 50, 200);
      if (fire_ack || bullet_active != 0) seen_ack = 1;
    end
    chk("rst_held_no_fire", seen_ack, 0);
    cycle(1'b0, 1'b0, 50, 200);
    press(200);
    chk("rst_repress_ack", fire_ack, 1'b1);

    // Randomized traffic against the model.
    cycle(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, b;
      int   sx, sy;
      r  = ($urandom_range(0, 299) == 0);
      b  = ($urandom_range(0, 3) == 0) ? ~btn_fire : btn_fire;
      sx = $urandom_range(0, 1023);
      sy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 60);
      cycle(r, b, sx, sy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_pool_controller.md
BULLET_POOL_CONTROLLER -- requirements
Module: bullet_pool_controller

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of independent bullet slots (2..8).
REQ-002 SHALL have parameter TICK_BIT, default 17, move-counter bit that generates a movement tick.
REQ-003 SHALL have parameter BULLET_SPEED, default 2, pixels moved upward per tick.
REQ-004 SHALL have parameter COOLDOWN_TICKS, default 16, ticks between launches (only with BULLET_COOLDOWN_EN).
REQ-005 SHALL have parameters SPRITE_W, default 32, BULLET_W, default 4, and BULLET_H, default 8, all in pixels.
REQ-006 SHALL have port clk25  input  1  25 MHz pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port btn_fire  input  1  fire button level, already synchronous to clk25.
REQ-009 SHALL have port sprite_x  input  10  user sprite left edge.
REQ-010 SHALL have port sprite_y  input  10  user sprite top edge.
REQ-011 SHALL have port bullet_x  output  10*NUM_SLOTS  packed x positions, slot i at bits [10i+9:10i].
REQ-012 SHALL have port bullet_y  output  10*NUM_SLOTS  packed y positions, same packing.
REQ-013 SHALL have port bullet_active  output  NUM_SLOTS  per-slot active flag.
REQ-014 SHALL have port fire_ack  output  1  one-cycle pulse on the cycle a bullet launches.
REQ-015 SHALL have port pool_full  output  1  high when all slots are active.

Function
REQ-016 SHALL hold a 20-bit move counter incremented every cycle; when counter[TICK_BIT] is 1 the counter SHALL clear and an internal tick SHALL pulse for one cycle (period 2^TICK_BIT+1 cycles).
REQ-017 SHALL register btn_fire once and detect its rising edge; a rising edge SHALL set fire_pending.
REQ-018 A rising edge while fire_pending is already set SHALL be dropped, not queued.
REQ-019 A launch SHALL occur in the cycle where fire_pending is set, at least one slot is inactive, and launch is not cooldown-blocked; fire_pending SHALL clear in that cycle.
REQ-020 The launched slot SHALL be the first inactive slot found by searching upward from the round-robin pointer rr, wrapping at NUM_SLOTS; rr SHALL then become (chosen+1) mod NUM_SLOTS.
REQ-021 On launch, the slot SHALL load x = sprite_x + SPRITE_W/2 - BULLET_W/2 and y = sprite_y - BULLET_H, with y = 0 when sprite_y < BULLET_H; active SHALL be set.
REQ-022 fire_ack SHALL be registered and high for exactly the one cycle after the launch decision, aligned with the updated bullet_active.
REQ-023 On tick, each slot active before the cycle SHALL do this: if y < BULLET_SPEED, clear active and set x = y = 0; otherwise decrement y by BULLET_SPEED, leaving x unchanged.
REQ-024 A slot launched in a tick cycle SHALL NOT move in that cycle; other slots SHALL move normally.
REQ-025 A slot freed by a tick SHALL NOT be eligible for launch until the following cycle, because the free search uses the registered active mask.
REQ-026 Inactive slots SHALL drive x = y = 0.
REQ-027 pool_full SHALL equal the AND of the registered bullet_active bits.
REQ-028 While pool_full is high, fire_pending SHALL be held until a slot frees.
REQ-029 All arithmetic SHALL be 10-bit unsigned, with no wrap below 0.

Reset
REQ-030 When rst is high at a clock edge, the following SHALL clear to 0 on that edge, overriding any launch or tick in the same cycle: move counter, registered btn_fire, fire_pending, rr, all slot x/y/active, fire_ack and cooldown counter.
REQ-031 A btn_fire held high through reset release SHALL NOT fire until it is released and pressed again.

Configuration
REQ-032 With macro BULLET_COOLDOWN_EN defined:
- a cooldown counter SHALL load COOLDOWN_TICKS on every launch;
- it SHALL decrement by 1 per tick, saturating at 0;
- launch SHALL be blocked while the counter is nonzero.
REQ-033 Without BULLET_COOLDOWN_EN, no cooldown logic SHALL exist, and launch SHALL be gated only by fire_pending and free-slot availability.

Verification (TICK_BIT=3, so period 9; NUM_SLOTS=4, BULLET_SPEED=2)
REQ-034 Fire at sprite_x=100, sprite_y=200 -> fire_ack pulses once; slot 0 active with x=114, y=192; after 1 tick y=190.
REQ-035 Fire at sprite_y=4 -> y=0; on the next tick the slot deactivates and x=y=0.
REQ-036 Five separated presses with cooldown off and no ticks -> slots 0,1,2,3 fill and pool_full=1; the fifth press stays pending; launch fires one cycle after the first slot frees.
REQ-037 Free slot 1 only while rr=2, then fire -> slot 2 is skipped if active and slot 1 is chosen via wrap-around search; rr becomes 2.
REQ-038 Cooldown on (COOLDOWN_TICKS=3): two presses 1 cycle apart -> the second launches only after 3 ticks; cooldown off -> the second launches immediately.
REQ-039 Assert rst during a launch-and-tick cycle with btn_fire held -> all outputs 0 next cycle; no fire until btn_fire is released and pressed again.
